// File: rtl/rf_alu_pkg.sv
// Shared definitions for the register-file / ALU sequencer: ALU codes,
// FSM state names, the command record and the op legality rule.
package rf_alu_pkg;

  localparam int CMD_DATA_W = 8;
  localparam int CMD_ADDR_W = 3;
  localparam int CMD_OP_W   = 3;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    logic                  ld;
    logic [CMD_OP_W-1:0]   op;
    logic [CMD_ADDR_W-1:0] rd;
    logic [CMD_ADDR_W-1:0] rs;
    logic [CMD_ADDR_W-1:0] rt;
    logic                  use_imm;
    logic [CMD_DATA_W-1:0] imm;
  } cmd_t;

  // Codes 011/100/101 have no ALU function and are rejected.
  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rf_alu_sequencer.sv
// Valid/ready command sequencer for the 8-entry register file and ALU.
// Optional build macro RF_ALU_SEQ_FWD_EN adds a last-write bypass so that a
// register file which commits its write after the write-back edge still
// feeds the next command the right operand.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// READ  | drive rs/rt read addresses, latch operands
// EXEC  | drive ALU, latch result and zero flag
// WB    | write result to rd (suppressed for rd == 0), pulse done
module rf_alu_sequencer
  import rf_alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ld,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_zero,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              err
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_READ = ST_READ;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_WB   = ST_WB;

  logic [1:0]        state;
  logic              c_ld;
  logic [OP_W-1:0]   c_op;
  logic [ADDR_W-1:0] c_rd, c_rs, c_rt;
  logic              c_use_imm;
  logic [DATA_W-1:0] c_imm;
  logic [DATA_W-1:0] op_a, op_b, result_q;
  logic              zero_q, err_q;
  logic [DATA_W-1:0] src_a, src_b;

`ifdef RF_ALU_SEQ_FWD_EN
  logic              fwd_vld;
  logic [ADDR_W-1:0] fwd_rd;

  // Remember the destination of the last write; rd == 0 never forwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_vld <= 1'b0;
      fwd_rd  <= '0;
    end else if (state == S_WB) begin
      fwd_vld <= (c_rd != '0);
      fwd_rd  <= c_rd;
    end
  end

  assign src_a = (fwd_vld && (c_rs == fwd_rd)) ? result_q : rf_rd1;
  assign src_b = (fwd_vld && (c_rt == fwd_rd)) ? result_q : rf_rd2;
`else
  assign src_a = rf_rd1;
  assign src_b = rf_rd2;
`endif

  // State transitions plus command, operand and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      c_ld      <= 1'b0;
      c_op      <= '0;
      c_rd      <= '0;
      c_rs      <= '0;
      c_rt      <= '0;
      c_use_imm <= 1'b0;
      c_imm     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            c_ld      <= cmd_ld;
            c_op      <= cmd_op;
            c_rd      <= cmd_rd;
            c_rs      <= cmd_rs;
            c_rt      <= cmd_rt;
            c_use_imm <= cmd_use_imm;
            c_imm     <= cmd_imm;
            if (cmd_ld)                   state <= S_WB;
            else if (!is_legal_op(cmd_op)) err_q <= 1'b1;
            else                          state <= S_READ;
          end
        end
        S_READ: begin
          op_a  <= src_a;
          op_b  <= c_use_imm ? c_imm : src_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= alu_y;
          zero_q   <= alu_zero;
          state    <= S_WB;
        end
        default: begin
          // A load becomes the held result at write-back; zero flag untouched.
          if (c_ld) result_q <= c_imm;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore output decode; everything idles at zero outside its own state.
  always_comb begin
    cmd_ready = 1'b0;
    rf_ra1    = '0;
    rf_ra2    = '0;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = '0;
    done      = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_READ: begin
        rf_ra1 = c_rs;
        rf_ra2 = c_rt;
      end
      S_EXEC: begin
        alu_a    = op_a;
        alu_b    = op_b;
        alu_ctrl = c_op;
      end
      S_WB: begin
        rf_we = (c_rd != '0);
        rf_wa = c_rd;
        rf_wd = c_ld ? c_imm : result_q;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign result    = result_q;
  assign zero_flag = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Self-checking bench for rf_alu_sequencer: behavioural register file and
// ALU around the DUT, reference model of architectural register contents.
module tb_rf_alu_sequencer;
  import rf_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ld = 1'b0, cmd_use_imm = 1'b0;
  logic [2:0] cmd_op = '0, cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
  logic [7:0] cmd_imm = '0;
  logic       cmd_ready, rf_we, alu_zero, done, zero_flag, err;
  logic [2:0] rf_ra1, rf_ra2, rf_wa, alu_ctrl;
  logic [7:0] rf_rd1, rf_rd2, rf_wd, alu_a, alu_b, alu_y, result;

  always #5 clk = ~clk;

  rf_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld(cmd_ld), .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs),
    .cmd_rt(cmd_rt), .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_y(alu_y), .alu_zero(alu_zero), .done(done),
    .result(result), .zero_flag(zero_flag), .err(err)
  );

  // Environment ALU: MIPS-style codes, signed set-less-than.
  function automatic logic [7:0] alu_fn(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  assign alu_y    = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_zero = (alu_y == 8'd0);

  // Environment register file, combinational read, $0 hardwired.
  logic [7:0] rf_mem [8] = '{default: 8'h00};
  assign rf_rd1 = rf_mem[rf_ra1];
  assign rf_rd2 = rf_mem[rf_ra2];

`ifdef RF_ALU_SEQ_FWD_EN
  // Slow register file: the write lands two edges after write-back.
  logic       we_d1 = 1'b0, we_d2 = 1'b0;
  logic [2:0] wa_d1 = '0, wa_d2 = '0;
  logic [7:0] wd_d1 = '0, wd_d2 = '0;
  always @(posedge clk) begin
    we_d1 <= rf_we; wa_d1 <= rf_wa; wd_d1 <= rf_wd;
    we_d2 <= we_d1; wa_d2 <= wa_d1; wd_d2 <= wd_d1;
    if (we_d2 && wa_d2 != 3'd0) rf_mem[wa_d2] <= wd_d2;
  end
`else
  always @(posedge clk) begin
    if (rf_we && rf_wa != 3'd0) rf_mem[rf_wa] <= rf_wd;
  end
`endif

  // Event monitor sampled away from the active edge.
  int          done_cnt = 0, we_cnt = 0, acc_cnt = 0;
  logic [11:0] wb_log[$];
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      wb_log.push_back({rf_we, rf_wa, rf_wd});
    end
    if (rf_we === 1'b1) we_cnt++;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_cnt++;
  end

  int n_checks = 0, n_fail = 0;

  // Reference model: architectural register values and held outputs.
  logic [7:0] ref_regs [8] = '{default: 8'h00};
  logic [7:0] exp_result = 8'h00;
  logic       exp_zero = 1'b0;

  function automatic logic ref_illegal(input cmd_t c);
    return !c.ld && (c.op == 3'b011 || c.op == 3'b100 || c.op == 3'b101);
  endfunction

  function automatic logic [7:0] ref_value(input cmd_t c);
    if (c.ld) return c.imm;
    return alu_fn(c.op, ref_regs[c.rs], c.use_imm ? c.imm : ref_regs[c.rt]);
  endfunction

  task automatic ref_apply(input cmd_t c);
    logic [7:0] v;
    if (ref_illegal(c)) return;
    v = ref_value(c);
    exp_result = v;
    if (!c.ld) exp_zero = (v == 8'd0);
    if (c.rd != 3'd0) ref_regs[c.rd] = v;
  endtask

  function automatic cmd_t mk(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                              input logic [2:0] rs, input logic [2:0] rt, input logic ui,
                              input logic [7:0] imm);
    cmd_t c;
    c.ld = ld; c.op = op; c.rd = rd; c.rs = rs; c.rt = rt; c.use_imm = ui; c.imm = imm;
    return c;
  endfunction

  // Present a command (caller sits just after a posedge) and wait for its handshake.
  task automatic present(input cmd_t c, output bit ok);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_ld = c.ld; cmd_op = c.op; cmd_rd = c.rd;
    cmd_rs = c.rs; cmd_rt = c.rt; cmd_use_imm = c.use_imm; cmd_imm = c.imm;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = (cmd_ready === 1'b1);
    @(posedge clk); #1;
  endtask

  // Issue one command and record the first done/err cycle after the handshake.
  task automatic run_cmd(input cmd_t c, output int lat, output logic we, output logic [2:0] wa,
                         output logic [7:0] wd, output logic er, output logic rdy1);
    bit ok;
    @(posedge clk); #1;
    present(c, ok);
    cmd_valid = 1'b0;
    lat = 0; we = 1'b0; wa = '0; wd = '0; er = 1'b0; rdy1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) rdy1 = cmd_ready;
      if (ok && lat == 0 && (done === 1'b1 || err === 1'b1)) begin
        lat = i; we = rf_we; wa = rf_wa; wd = rf_wd; er = err;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, done, rf_we, err, zero_flag} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=10000", {cmd_ready, done, rf_we, err, zero_flag});
    end
    n_checks++;
    if ({result, rf_ra1, rf_ra2, rf_wa, alu_ctrl, alu_a, alu_b} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_buses got=%h exp=0", {result, rf_ra1, rf_ra2, rf_wa, alu_ctrl, alu_a, alu_b});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_directed();
    cmd_t       tc [10];
    logic [7:0] tw [10];
    int lat; logic we, er, rdy; logic [2:0] wa; logic [7:0] wd;
    tc[0] = mk(1, 3'b000, 5, 0, 0, 0, 8'h06); tw[0] = 8'h06;
    tc[1] = mk(1, 3'b000, 2, 0, 0, 0, 8'h03); tw[1] = 8'h03;
    tc[2] = mk(0, ALU_ADD, 3, 5, 2, 0, 8'h00); tw[2] = 8'h09;
    tc[3] = mk(0, ALU_SUB, 3, 5, 2, 0, 8'h00); tw[3] = 8'h03;
    tc[4] = mk(0, ALU_AND, 3, 5, 2, 0, 8'h00); tw[4] = 8'h02;
    tc[5] = mk(0, ALU_OR,  3, 5, 2, 0, 8'h00); tw[5] = 8'h07;
    tc[6] = mk(0, ALU_SLT, 3, 5, 2, 0, 8'h00); tw[6] = 8'h00;
    tc[7] = mk(0, ALU_SLT, 3, 2, 5, 0, 8'h00); tw[7] = 8'h01;
    tc[8] = mk(0, ALU_ADD, 4, 5, 0, 1, 8'h0A); tw[8] = 8'h10;
    tc[9] = mk(0, ALU_ADD, 0, 5, 2, 0, 8'h00); tw[9] = 8'h09;
    for (int i = 0; i < 10; i++) begin
      run_cmd(tc[i], lat, we, wa, wd, er, rdy);
      ref_apply(tc[i]);
      n_checks++;
      if ({8'(lat), we, wa, wd, er} !== {(tc[i].ld ? 8'd1 : 8'd3), (tc[i].rd != 3'd0), tc[i].rd, tw[i], 1'b0}) begin
        n_fail++;
        $display("FAIL directed_%0d lat/we/wa/wd/err got=%0d/%b/%0d/%h/%b exp=%0d/%b/%0d/%h/0", i, lat, we, wa, wd, er,
                 tc[i].ld ? 1 : 3, tc[i].rd != 3'd0, tc[i].rd, tw[i]);
      end
      if (!tc[i].ld) begin
        n_checks++;
        if ({result, zero_flag} !== {tw[i], (tw[i] == 8'd0)}) begin
          n_fail++;
          $display("FAIL directed_%0d_held result/zero got=%h/%b exp=%h/%b", i, result, zero_flag, tw[i], tw[i] == 8'd0);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ill [3] = '{3'b011, 3'b100, 3'b101};
    int lat, d0; logic we, er, rdy; logic [2:0] wa; logic [7:0] wd;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      run_cmd(mk(0, ill[i], 6, 5, 2, 0, 8'h00), lat, we, wa, wd, er, rdy);
      n_checks++;
      if ({8'(lat), we, er, rdy, 8'(done_cnt - d0), result} !== {8'd1, 1'b0, 1'b1, 1'b1, 8'd0, exp_result}) begin
        n_fail++;
        $display("FAIL illegal_op_%b lat/we/err/ready/dones/result got=%0d/%b/%b/%b/%0d/%h exp=1/0/1/1/0/%h",
                 ill[i], lat, we, er, rdy, done_cnt - d0, result, exp_result);
      end
    end
  endtask

  task automatic test_busy_hold();
    cmd_t c; bit ok; int a0, d0;
    c = mk(0, ALU_ADD, 1, 5, 2, 0, 8'h00);
    a0 = acc_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    present(c, ok);
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    ref_apply(c);
    n_checks++;
    if ({8'(acc_cnt - a0), 8'(done_cnt - d0), wb_log[$]} !== {8'd1, 8'd1, 1'b1, 3'd1, ref_regs[1]}) begin
      n_fail++;
      $display("FAIL busy_hold accepts/dones/last_wb got=%0d/%0d/%h exp=1/1/%h", acc_cnt - a0, done_cnt - d0,
               wb_log[$], {1'b1, 3'd1, ref_regs[1]});
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int d0, w0;
    d0 = done_cnt; w0 = we_cnt;
    @(posedge clk); #1;
    present(mk(0, ALU_ADD, 3, 5, 2, 0, 8'h00), ok);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, done, rf_we, zero_flag, result} !== {4'b1000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid ready/done/we/zero/result got=%b/%b/%b/%b/%h exp=1/0/0/0/00",
               cmd_ready, done, rf_we, zero_flag, result);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if ({8'(done_cnt - d0), 8'(we_cnt - w0)} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_dropped dones/writes got=%0d/%0d exp=0/0", done_cnt - d0, we_cnt - w0);
    end
    exp_result = 8'h00;
    exp_zero   = 1'b0;
  endtask

  task automatic test_back_to_back();
    cmd_t c [3]; logic [11:0] exp [3]; bit ok; int s0;
    c[0] = mk(1, 3'b000, 4, 0, 0, 0, 8'h11);
    c[1] = mk(0, ALU_ADD, 6, 4, 4, 0, 8'h00);
    c[2] = mk(0, ALU_ADD, 7, 6, 4, 0, 8'h00);
    s0 = wb_log.size();
    for (int i = 0; i < 3; i++) begin
      exp[i] = {1'b1, c[i].rd, ref_value(c[i])};
      ref_apply(c[i]);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) present(c[i], ok);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (wb_log.size() != s0 + 3) begin
      n_fail++;
      $display("FAIL back_to_back_count got=%0d exp=3", wb_log.size() - s0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wb_log[s0 + i] !== exp[i]) begin
          n_fail++;
          $display("FAIL back_to_back_%0d we/wa/wd got=%h exp=%h", i, wb_log[s0 + i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] legal [5] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    logic [2:0] ill [3] = '{3'b011, 3'b100, 3'b101};
    cmd_t c; logic [20:0] exp_v;
    int lat; logic we, er, rdy; logic [2:0] wa; logic [7:0] wd;
    for (int n = 0; n < 40; n++) begin
      c.ld      = ($urandom_range(0, 3) == 0);
      c.op      = ($urandom_range(0, 7) == 0) ? ill[$urandom_range(0, 2)] : legal[$urandom_range(0, 4)];
      c.rd      = 3'($urandom_range(0, 7));
      c.rs      = 3'($urandom_range(0, 7));
      c.rt      = 3'($urandom_range(0, 7));
      c.use_imm = 1'($urandom_range(0, 1));
      c.imm     = 8'($urandom_range(0, 255));
      if (ref_illegal(c)) exp_v = {8'd1, 1'b0, 3'd0, 8'd0, 1'b1};
      else exp_v = {(c.ld ? 8'd1 : 8'd3), (c.rd != 3'd0), c.rd, ref_value(c), 1'b0};
      run_cmd(c, lat, we, wa, wd, er, rdy);
      ref_apply(c);
      n_checks++;
      if ({8'(lat), we, wa, wd, er} !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d lat/we/wa/wd/err got=%h exp=%h cmd=%h", n, {8'(lat), we, wa, wd, er}, exp_v, c);
      end
      n_checks++;
      if ({result, zero_flag} !== {exp_result, exp_zero}) begin
        n_fail++;
        $display("FAIL random_%0d_held result/zero got=%h/%b exp=%h/%b", n, result, zero_flag, exp_result, exp_zero);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule
